// File: rtl/boot_sequencer_if.sv
// Boot sequencer signal bundle.
// Groups the PLL/bootloader-side inputs and the bootloader reset plus
// SB_WARMBOOT outputs of the boot sequencer into one port.
//   pll_lock      : PLL LOCK, already synchronous to clk_48mhz
//   boot_req      : boot level from tinyfpga_bootloader
//   core_reset    : active-high reset to tinyfpga_bootloader
//   warmboot_s1   : SB_WARMBOOT S1
//   warmboot_s0   : SB_WARMBOOT S0
//   warmboot_boot : SB_WARMBOOT BOOT (sticky until reset)
//   busy          : high whenever the sequencer is not in RUN
// Modports:
//   master : the sequencer (drives reset/warmboot/busy)
//   slave  : the board side (drives pll_lock/boot_req)
interface boot_sequencer_if;
    logic pll_lock;
    logic boot_req;
    logic core_reset;
    logic warmboot_s1;
    logic warmboot_s0;
    logic warmboot_boot;
    logic busy;

    modport master (
        input  pll_lock,
        input  boot_req,
        output core_reset,
        output warmboot_s1,
        output warmboot_s0,
        output warmboot_boot,
        output busy
    );

    modport slave (
        output pll_lock,
        output boot_req,
        input  core_reset,
        input  warmboot_s1,
        input  warmboot_s0,
        input  warmboot_boot,
        input  busy
    );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer for the Catena 4710 bootloader.
// Holds tinyfpga_bootloader in reset until PLL lock has been stable for
// LOCK_CYCLES, then on a boot request waits BOOT_DELAY_CYCLES (so the last
// USB handshake completes) before driving SB_WARMBOOT BOOT.
// Ports:
//   i_clk_48mhz : PLL output clock, rising-edge logic
//   i_reset     : synchronous active-high reset
//   bus         : boot_sequencer_if.master (pll_lock, boot_req in;
//                 core_reset, warmboot_s1/s0/boot, busy out; all registered)
//
// state       | meaning
// ------------+--------------------------------------------------------
// LOCK_WAIT   | core held in reset, counting consecutive pll_lock samples
// RUN         | core running, waiting for a boot request
// BOOT_DELAY  | request latched, counting guard delay, core still running
// BOOT_ASSERT | warmboot issued, core in reset; left only by i_reset
module boot_sequencer #(
    parameter int          LOCK_CYCLES       = 4800,
    parameter int          BOOT_DELAY_CYCLES = 48000,
    parameter logic [1:0]  BOOT_IMAGE        = 2'b01
) (
    input  logic              i_clk_48mhz,
    input  logic              i_reset,
    boot_sequencer_if.master  bus
);

    localparam int CNT_MAX_VAL = (LOCK_CYCLES > BOOT_DELAY_CYCLES) ? LOCK_CYCLES : BOOT_DELAY_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(BOOT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        LOCK_WAIT   = 2'd0,
        RUN         = 2'd1,
        BOOT_DELAY  = 2'd2,
        BOOT_ASSERT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_core_reset;
    logic             r_boot;
    logic             r_busy;
    logic [1:0]       r_image;
    logic             w_core_reset_nxt;
    logic             w_boot_nxt;
    logic             w_busy_nxt;

    // Saturating increment: the counter never wraps even if a terminal
    // compare were somehow missed.
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LOCK_WAIT: begin
                if (!bus.pll_lock) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RUN: begin
                // Loss of lock wins over a simultaneous request.
                if (!bus.pll_lock) begin
                    w_state_nxt = LOCK_WAIT;
                    w_cnt_nxt   = '0;
                end else if (bus.boot_req) begin
                    w_state_nxt = BOOT_DELAY;
                    w_cnt_nxt   = '0;
                end
            end
            BOOT_DELAY: begin
                if (!bus.pll_lock) begin
                    w_state_nxt = LOCK_WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DELAY_LAST) begin
                    w_state_nxt = BOOT_ASSERT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            BOOT_ASSERT: begin
                w_state_nxt = BOOT_ASSERT;
            end
            default: begin
                w_state_nxt = LOCK_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_comb begin
        w_core_reset_nxt = !((w_state_nxt == RUN) || (w_state_nxt == BOOT_DELAY));
        w_boot_nxt       = (w_state_nxt == BOOT_ASSERT);
        w_busy_nxt       = (w_state_nxt != RUN);
    end

    always_ff @(posedge i_clk_48mhz) begin
        if (i_reset) begin
            r_state      <= LOCK_WAIT;
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
            r_boot       <= 1'b0;
            r_busy       <= 1'b1;
            r_image      <= BOOT_IMAGE;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_boot       <= w_boot_nxt;
            r_busy       <= w_busy_nxt;
            r_image      <= BOOT_IMAGE;
        end
    end

    assign bus.core_reset    = r_core_reset;
    assign bus.warmboot_boot = r_boot;
    assign bus.busy          = r_busy;
    assign bus.warmboot_s1   = r_image[1];
    assign bus.warmboot_s0   = r_image[0];

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sequencing stage directly downstream of tinyfpga_bootloader on the Catena 4710.
- Holds the bootloader core in reset until PLL lock has been stable for a programmable time.
- Consumes the bootloader's boot request, waits a guard delay so the final USB handshake completes, then drives SB_WARMBOOT S1/S0/BOOT to jump to the user image.
- Replaces the constant-0 reset and the disabled warmboot path at board top level.

Parameters:
- LOCK_CYCLES, 4800: consecutive clk_48mhz cycles of pll_lock=1 required before core_reset deasserts (100 us at 48 MHz); minimum 1.
- BOOT_DELAY_CYCLES, 48000: cycles between accepted boot request and warmboot_boot assertion (1 ms); minimum 1.
- BOOT_IMAGE, 2'b01: value driven onto {warmboot_s1, warmboot_s0}.

Ports:
- clk_48mhz  input  1  PLL output clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pll_lock  input  1  PLL LOCK, already synchronous to clk_48mhz.
- boot_req  input  1  boot level from tinyfpga_bootloader.
- core_reset  output  1  reset to tinyfpga_bootloader, active-high, registered.
- warmboot_s1  output  1  SB_WARMBOOT S1, registered.
- warmboot_s0  output  1  SB_WARMBOOT S0, registered.
- warmboot_boot  output  1  SB_WARMBOOT BOOT, registered, sticky.
- busy  output  1  high in any state other than RUN.

Behaviour:
- Reset (synchronous):
  - state=LOCK_WAIT, counter=0.
  - core_reset=1, warmboot_boot=0, {s1,s0}=BOOT_IMAGE, busy=1.
  - Reset overrides every state, including BOOT_ASSERT.
- Counter: one shared counter, width $clog2(max(LOCK_CYCLES, BOOT_DELAY_CYCLES)+1). It saturates and never wraps.
- LOCK_WAIT:
  - pll_lock=0: counter cleared to 0.
  - pll_lock=1: counter increments.
  - On the cycle where pll_lock=1 and counter==LOCK_CYCLES-1: next state RUN, counter cleared, core_reset registers to 0.
  - First core_reset=0 is visible exactly LOCK_CYCLES cycles after the first of LOCK_CYCLES consecutive lock-high samples.
  - boot_req is ignored.
- RUN:
  - core_reset=0, busy=0.
  - pll_lock=0 takes priority: next state LOCK_WAIT, core_reset=1 next cycle, counter=0.
  - Otherwise boot_req=1: next state BOOT_DELAY, counter=0, busy=1 next cycle.
- BOOT_DELAY:
  - core_reset stays 0 so the bootloader can finish its USB response.
  - Counter increments each cycle. When counter==BOOT_DELAY_CYCLES-1: next state BOOT_ASSERT, warmboot_boot=1 next cycle.
  - warmboot_boot first rises BOOT_DELAY_CYCLES+1 cycles after the RUN cycle that sampled boot_req=1.
  - boot_req deasserting during BOOT_DELAY does not cancel (request is latched).
  - pll_lock=0 during BOOT_DELAY aborts: next state LOCK_WAIT, core_reset=1, counter=0, boot not issued.
- BOOT_ASSERT:
  - Terminal state. warmboot_boot=1 and core_reset=1 (asserted the same cycle as warmboot_boot).
  - pll_lock and boot_req are ignored. Exit only via reset.
- {warmboot_s1, warmboot_s0} are constant BOOT_IMAGE at all times after reset; they never glitch.
- Simultaneous events: pll_lock=0 with boot_req=1 in RUN goes to LOCK_WAIT, and the request is dropped.
- Illegal or unreached state encodings recover to LOCK_WAIT with outputs as at reset.

Test Plan:
All scenarios use LOCK_CYCLES=8, BOOT_DELAY_CYCLES=16, BOOT_IMAGE=2'b10.
- Power-up: reset 2 cycles, then pll_lock=1 continuously -> core_reset=1 for 8 cycles after reset release, 0 from cycle 9; busy falls the same cycle; s1=1, s0=0 throughout.
- Lock glitch: pll_lock=1 for 5 cycles, 0 for 1, then 1 -> core_reset deasserts 8 cycles after the relock, not before.
- Boot: in RUN, pulse boot_req for 1 cycle at cycle T -> warmboot_boot=0 through T+16 and 1 at T+17 onward; core_reset=1 from T+17; both remain high with pll_lock toggling for 100 cycles.
- Abort: boot_req at T, pll_lock=0 at T+5 -> warmboot_boot never asserts; core_reset=1 at T+6; relock for 8 cycles -> RUN and busy=0.
- Priority: boot_req=1 and pll_lock=0 in the same RUN cycle -> LOCK_WAIT; no boot after relock unless boot_req is re-asserted.
- Reset in BOOT_ASSERT: assert reset -> next cycle warmboot_boot=0, core_reset=1, busy=1, state LOCK_WAIT.
